// File: rtl/xmit_pkg.sv
// xmit_pkg: shared types and control-word field constants for the transmit path
package xmit_pkg;
  typedef enum logic [2:0] {IDLE, POP, CHECK, WAIT_DONE, GAP} state_t;
  localparam int CTRL_W = 24;
  localparam int CTRL_LEN_MSB = 11;
  localparam int CTRL_LEN_LSB = 0;
  localparam int LEN_W = 12;
endpackage

// File: rtl/xmit_prio_sched.sv
// xmit_prio_sched: two-queue transmit frame scheduler with burst limit, length check and inter-frame gap
module xmit_prio_sched
  import xmit_pkg::*;
#(
  parameter int HI_BURST = 4,
  parameter int IFG_CYCLES = 12,
  parameter logic [LEN_W-1:0] MIN_LEN = 12'd64,
  parameter logic [LEN_W-1:0] MAX_LEN = 12'd1518
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              f_hi_ctrl_avail,
  input  logic [CTRL_W-1:0] f_hi_ctrl,
  input  logic              f_lo_ctrl_avail,
  input  logic [CTRL_W-1:0] f_lo_ctrl,
  output logic              s_hi_pop,
  output logic              s_lo_pop,
  output logic              s_tx_start,
  output logic              s_tx_sel,
  output logic [LEN_W-1:0]  s_tx_len,
  input  logic              t_tx_done,
  output logic              s_discard,
  output logic              s_busy,
  output logic [15:0]       s_hi_count,
  output logic [15:0]       s_lo_count
);
  localparam logic [7:0] HB = 8'(HI_BURST);
  localparam logic [15:0] GAP_LD = 16'(IFG_CYCLES - 1);
  state_t state, state_n;
  logic [LEN_W-1:0] len_q, len_q_n, len_n;
  logic [15:0] hi_cnt_n, lo_cnt_n, gap_cnt, gap_n;
  logic [7:0] burst, burst_n;
  logic lo_pend, lo_pend_n, sel_n, hi_pop_n, lo_pop_n, start_n, discard_n;
  logic pick_hi, legal, unused_ctrl;
  assign pick_hi = f_hi_ctrl_avail && (!f_lo_ctrl_avail || burst < HB);
  assign legal = len_q >= MIN_LEN && len_q <= MAX_LEN;
  assign unused_ctrl = ^{f_hi_ctrl[CTRL_W-1:CTRL_LEN_MSB+1], f_lo_ctrl[CTRL_W-1:CTRL_LEN_MSB+1]};
  // Next-state and next-output logic; every output is registered from these
  always_comb begin
    state_n = state;
    len_q_n = len_q;
    lo_pend_n = lo_pend;
    sel_n = s_tx_sel;
    len_n = s_tx_len;
    hi_cnt_n = s_hi_count;
    lo_cnt_n = s_lo_count;
    burst_n = burst;
    gap_n = gap_cnt;
    hi_pop_n = 1'b0;
    lo_pop_n = 1'b0;
    start_n = 1'b0;
    discard_n = 1'b0;
    case (state)
      IDLE: if (f_hi_ctrl_avail || f_lo_ctrl_avail) begin
        state_n = POP;
        sel_n = pick_hi;
        len_q_n = pick_hi ? f_hi_ctrl[CTRL_LEN_MSB:CTRL_LEN_LSB] : f_lo_ctrl[CTRL_LEN_MSB:CTRL_LEN_LSB];
        lo_pend_n = f_lo_ctrl_avail;
        hi_pop_n = pick_hi;
        lo_pop_n = !pick_hi;
      end
      POP: begin
        state_n = CHECK;
        start_n = legal;
        discard_n = !legal;
        if (legal) begin
          len_n = len_q;
          hi_cnt_n = s_hi_count + {15'd0, s_tx_sel};
          lo_cnt_n = s_lo_count + {15'd0, !s_tx_sel};
          burst_n = (s_tx_sel && lo_pend) ? burst + {7'd0, burst < HB} : 8'd0;
        end
      end
      CHECK: state_n = s_tx_start ? WAIT_DONE : IDLE;
      WAIT_DONE: if (t_tx_done) begin
        state_n = (IFG_CYCLES == 0) ? IDLE : GAP;
        gap_n = GAP_LD;
      end
      GAP: begin
        state_n = (gap_cnt == 16'd0) ? IDLE : GAP;
        gap_n = gap_cnt - 16'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state <= IDLE;
      len_q <= '0;
      lo_pend <= 1'b0;
      burst <= '0;
      gap_cnt <= '0;
      s_hi_pop <= 1'b0;
      s_lo_pop <= 1'b0;
      s_tx_start <= 1'b0;
      s_tx_sel <= 1'b0;
      s_tx_len <= '0;
      s_discard <= 1'b0;
      s_busy <= 1'b0;
      s_hi_count <= '0;
      s_lo_count <= '0;
    end else begin
      state <= state_n;
      len_q <= len_q_n;
      lo_pend <= lo_pend_n;
      burst <= burst_n;
      gap_cnt <= gap_n;
      s_hi_pop <= hi_pop_n;
      s_lo_pop <= lo_pop_n;
      s_tx_start <= start_n;
      s_tx_sel <= sel_n;
      s_tx_len <= len_n;
      s_discard <= discard_n;
      s_busy <= state_n != IDLE;
      s_hi_count <= hi_cnt_n;
      s_lo_count <= lo_cnt_n;
    end
  end
endmodule

// File: tb/tb_xmit_prio_sched.sv
// tb_xmit_prio_sched: scoreboard bench for xmit_prio_sched with FIFO and datapath stand-ins
module tb_xmit_prio_sched;
  typedef struct packed {
    logic disc;
    logic sel;
    logic [11:0] len;
    logic [15:0] hc;
    logic [15:0] lc;
  } ev_t;
  logic clk_sys = 1'b0;
  logic reset_n;
  logic f_hi_ctrl_avail = 1'b0, f_lo_ctrl_avail = 1'b0;
  logic [23:0] f_hi_ctrl = '0, f_lo_ctrl = '0;
  logic s_hi_pop, s_lo_pop, s_tx_start, s_tx_sel, s_discard, s_busy, t_tx_done;
  logic [11:0] s_tx_len;
  logic [15:0] s_hi_count, s_lo_count;
  logic h1_av, l1_av, hi_pop1, lo_pop1, start1, sel1, done1, disc1, busy1;
  logic [23:0] h1_ctrl, l1_ctrl;
  logic [11:0] len1;
  logic [15:0] hc1, lc1;
  int cyc = 0;
  int total = 0, bad = 0;
  int n_start = 0, n_done = 0, pop_cyc = 0, start_cyc = 0, disc_cyc = 0, prev_disc = 0;
  int man_req = 0, man_ack = 0, dcnt = 0;
  bit auto_done = 1'b1;
  logic [23:0] hi_q[$], lo_q[$];
  logic pop_q[$];
  ev_t ev_q[$];

  xmit_prio_sched dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .f_hi_ctrl_avail(f_hi_ctrl_avail), .f_hi_ctrl(f_hi_ctrl),
    .f_lo_ctrl_avail(f_lo_ctrl_avail), .f_lo_ctrl(f_lo_ctrl),
    .s_hi_pop(s_hi_pop), .s_lo_pop(s_lo_pop), .s_tx_start(s_tx_start),
    .s_tx_sel(s_tx_sel), .s_tx_len(s_tx_len), .t_tx_done(t_tx_done),
    .s_discard(s_discard), .s_busy(s_busy),
    .s_hi_count(s_hi_count), .s_lo_count(s_lo_count)
  );

  xmit_prio_sched #(.IFG_CYCLES(0)) dut_nogap (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .f_hi_ctrl_avail(h1_av), .f_hi_ctrl(h1_ctrl),
    .f_lo_ctrl_avail(l1_av), .f_lo_ctrl(l1_ctrl),
    .s_hi_pop(hi_pop1), .s_lo_pop(lo_pop1), .s_tx_start(start1),
    .s_tx_sel(sel1), .s_tx_len(len1), .t_tx_done(done1),
    .s_discard(disc1), .s_busy(busy1),
    .s_hi_count(hc1), .s_lo_count(lc1)
  );

  initial forever #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic expect_ev(input logic sel, input logic [11:0] len, input logic disc,
                           input logic [15:0] hc, input logic [15:0] lc);
    pop_q.push_back(sel);
    ev_q.push_back(ev_t'{disc, sel, len, hc, lc});
  endtask

  task automatic put(input logic sel, input logic [23:0] w);
    if (sel) hi_q.push_back(w);
    else lo_q.push_back(w);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    tick();
    while ((ev_q.size() != 0 || s_busy || hi_q.size() != 0 || lo_q.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) fail(nm);
  endtask

  task automatic wait_start(input int n0, input string nm);
    int n = 0;
    while (n_start <= n0 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) fail(nm);
  endtask

  // FIFO stand-ins: pop on the strobe, present the new head before the next edge
  initial forever begin
    @(posedge clk_sys);
    if (s_hi_pop === 1'b1 && hi_q.size() != 0) hi_q.delete(0);
    if (s_lo_pop === 1'b1 && lo_q.size() != 0) lo_q.delete(0);
    @(negedge clk_sys);
    f_hi_ctrl_avail = hi_q.size() != 0;
    f_hi_ctrl = hi_q.size() != 0 ? hi_q[0] : 24'h0;
    f_lo_ctrl_avail = lo_q.size() != 0;
    f_lo_ctrl = lo_q.size() != 0 ? lo_q[0] : 24'h0;
  end

  // Datapath stand-in: done three cycles after each start, or on request
  initial begin
    t_tx_done = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (s_tx_start === 1'b1 && auto_done) dcnt = 3;
      @(posedge clk_sys);
      #1;
      t_tx_done = 1'b0;
      if (man_req != man_ack) begin
        man_ack = man_req;
        t_tx_done = 1'b1;
      end else if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) t_tx_done = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk_sys);
    if (s_hi_pop === 1'b1 || s_lo_pop === 1'b1) begin
      if (s_hi_pop === 1'b1 && s_lo_pop === 1'b1) fail("pop_both");
      if (pop_q.size() == 0) fail("pop_unexpected");
      else chk("pop_sel", {31'd0, s_hi_pop}, {31'd0, pop_q.pop_front()});
      pop_cyc = cyc;
    end
    if (s_tx_start === 1'b1 || s_discard === 1'b1) begin
      if (ev_q.size() == 0) fail("event_unexpected");
      else begin
        ev_t e;
        e = ev_q.pop_front();
        chk("ev_discard", {31'd0, s_discard}, {31'd0, e.disc});
        chk("ev_start", {31'd0, s_tx_start}, {31'd0, !e.disc});
        if (!e.disc) begin
          chk("ev_sel", {31'd0, s_tx_sel}, {31'd0, e.sel});
          chk("ev_len", {20'd0, s_tx_len}, {20'd0, e.len});
        end
        chk("ev_hi_count", {16'd0, s_hi_count}, {16'd0, e.hc});
        chk("ev_lo_count", {16'd0, s_lo_count}, {16'd0, e.lc});
      end
      if (s_tx_start === 1'b1) begin
        start_cyc = cyc;
        n_start++;
      end else begin
        prev_disc = disc_cyc;
        disc_cyc = cyc;
      end
    end
    if (t_tx_done === 1'b1) n_done++;
  end

  initial begin
    int c0, d0, n, nb, n0, dd;
    reset_n = 1'b0;
    h1_av = 1'b0; l1_av = 1'b0; h1_ctrl = '0; l1_ctrl = '0; done1 = 1'b0;
    repeat (3) tick();
    @(negedge clk_sys);
    chk("rst_busy", {31'd0, s_busy}, 0);
    chk("rst_pops", {30'd0, s_hi_pop, s_lo_pop}, 0);
    chk("rst_start_disc", {30'd0, s_tx_start, s_discard}, 0);
    chk("rst_sel_len", {19'd0, s_tx_sel, s_tx_len}, 0);
    chk("rst_counts", {s_hi_count, s_lo_count}, 0);
    tick();
    reset_n = 1'b1;

    expect_ev(1'b1, 12'd64, 1'b0, 16'd1, 16'd0);
    c0 = cyc;
    put(1'b1, 24'h040040);
    wait_start(0, "t1_start_timeout");
    chk("t1_pop_latency", pop_cyc - c0, 1);
    chk("t1_start_latency", start_cyc - pop_cyc, 1);
    d0 = n_done;
    n = 0;
    while (n_done == d0 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) fail("t1_done_timeout");
    nb = 0;
    n = 0;
    while (n < 100) begin
      @(negedge clk_sys);
      if (!s_busy) break;
      nb++;
      n++;
    end
    chk("t1_gap_busy_cycles", nb, 12);
    chk("t1_hi_count", {16'd0, s_hi_count}, 1);
    wait_idle("t1_idle_timeout");

    for (int i = 0; i < 4; i++) expect_ev(1'b1, 12'(100 + i), 1'b0, 16'(2 + i), 16'd0);
    expect_ev(1'b0, 12'd600, 1'b0, 16'd5, 16'd1);
    for (int i = 4; i < 8; i++) expect_ev(1'b1, 12'(100 + i), 1'b0, 16'(2 + i), 16'd1);
    expect_ev(1'b0, 12'd601, 1'b0, 16'd9, 16'd2);
    for (int i = 0; i < 8; i++) put(1'b1, {12'h0AB, 12'(100 + i)});
    put(1'b0, {12'h0CD, 12'd600});
    put(1'b0, {12'h0CD, 12'd601});
    wait_idle("burst_idle_timeout");
    chk("burst_hi_count", {16'd0, s_hi_count}, 9);
    chk("burst_lo_count", {16'd0, s_lo_count}, 2);

    expect_ev(1'b0, 12'd512, 1'b0, 16'd9, 16'd3);
    n0 = n_start;
    put(1'b0, 24'h200200);
    wait_start(n0, "lo_start_timeout");
    expect_ev(1'b1, 12'd128, 1'b0, 16'd10, 16'd3);
    put(1'b1, 24'h000080);
    wait_idle("lo_idle_timeout");

    expect_ev(1'b1, 12'd0, 1'b1, 16'd10, 16'd3);
    expect_ev(1'b1, 12'd2000, 1'b1, 16'd10, 16'd3);
    expect_ev(1'b1, 12'd63, 1'b1, 16'd10, 16'd3);
    expect_ev(1'b1, 12'd1519, 1'b1, 16'd10, 16'd3);
    expect_ev(1'b1, 12'd1518, 1'b0, 16'd11, 16'd3);
    put(1'b1, 24'h000000);
    put(1'b1, 24'h0007D0);
    put(1'b1, 24'h00003F);
    put(1'b1, 24'h0005EF);
    put(1'b1, 24'h0005EE);
    wait_idle("disc_idle_timeout");
    chk("disc_spacing", disc_cyc - prev_disc, 3);

    auto_done = 1'b0;
    expect_ev(1'b1, 12'd64, 1'b0, 16'd12, 16'd3);
    n0 = n_start;
    put(1'b1, 24'h000040);
    wait_start(n0, "rst_frame_timeout");
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk_sys);
    chk("midrst_busy", {31'd0, s_busy}, 0);
    chk("midrst_pops", {30'd0, s_hi_pop, s_lo_pop}, 0);
    chk("midrst_start_disc", {30'd0, s_tx_start, s_discard}, 0);
    chk("midrst_sel_len", {19'd0, s_tx_sel, s_tx_len}, 0);
    chk("midrst_counts", {s_hi_count, s_lo_count}, 0);
    chk("midrst_pending", ev_q.size(), 0);
    man_req++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      chk("midrst_no_gap", {31'd0, s_busy}, 0);
    end
    auto_done = 1'b1;

    tick();
    h1_av = 1'b1;
    h1_ctrl = 24'h000040;
    n = 0;
    while (start1 !== 1'b1 && n < 50) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 50) fail("nogap_start_timeout");
    chk("nogap_sel_len", {19'd0, sel1, len1}, {19'd0, 1'b1, 12'd64});
    tick();
    tick();
    done1 = 1'b1;
    dd = cyc;
    tick();
    done1 = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk_sys);
      if (hi_pop1) break;
      n++;
    end
    chk("nogap_next_pop", cyc - dd, 2);
    chk("nogap_hi_count", {16'd0, hc1}, 1);
    h1_av = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/xmit_prio_sched.md
# xmit_prio_sched

Transmit-side frame scheduler for the xmit path, clocked on `clk_sys`. It arbitrates between the high-priority and low-priority control-word FIFOs and pops the winning control word. It then issues a start command (queue select plus length) to the transmit datapath, waits for frame completion, and enforces an inter-frame gap. A bounded high-priority burst limit prevents low-priority starvation, and malformed control words are discarded without transmission.

## Interface
Parameters:
- `HI_BURST`, default 4: maximum consecutive high grants while low is pending.
- `IFG_CYCLES`, default 12: idle `clk_sys` cycles after each transmitted frame. A value of 0 means no gap.
- `MIN_LEN`, default 12'd64: smallest legal frame length in bytes.
- `MAX_LEN`, default 12'd1518: largest legal frame length in bytes.

Ports:
- `clk_sys`  in  1  system clock; single clock domain.
- `reset_n`  in  1  reset, synchronous, active-low.
- `f_hi_ctrl_avail`  in  1  high control FIFO is non-empty.
- `f_hi_ctrl`  in  24  head word of the high FIFO; bits [11:0] are the frame length in bytes, bits [23:12] are carried but unused.
- `f_lo_ctrl_avail`  in  1  low control FIFO is non-empty.
- `f_lo_ctrl`  in  24  head word of the low FIFO; same format as `f_hi_ctrl`.
- `s_hi_pop`  out  1  one-cycle pop strobe to the high FIFO.
- `s_lo_pop`  out  1  one-cycle pop strobe to the low FIFO.
- `s_tx_start`  out  1  one-cycle start command to the transmit datapath.
- `s_tx_sel`  out  1  queue of the current frame; 1 = high, 0 = low.
- `s_tx_len`  out  12  length of the current frame.
- `t_tx_done`  in  1  one-cycle pulse from the datapath when the frame is fully sent.
- `s_discard`  out  1  one-cycle pulse when a popped word has an illegal length.
- `s_busy`  out  1  high in every state except IDLE.
- `s_hi_count`  out  16  count of transmitted high frames; wraps.
- `s_lo_count`  out  16  count of transmitted low frames; wraps.

## Operation
- All outputs are registered.
- Reset (`reset_n` = 0 at a clock edge):
  - The FSM goes to IDLE.
  - All strobes, `s_tx_sel`, `s_tx_len`, `s_busy`, both counters and the burst counter become 0.
  - Reset mid-frame abandons the frame with no pop, start or discard. The datapath is reset by the same reset.
- FSM states: IDLE, POP, CHECK, WAIT_DONE, GAP.
- IDLE, when any `avail` is high:
  - Select high if `f_hi_ctrl_avail` and (!`f_lo_ctrl_avail` or `burst_cnt` < `HI_BURST`); otherwise select low.
  - Latch the selected head word and set `s_tx_sel`.
  - Transition to POP.
- POP: assert the pop strobe of the selected queue for exactly one cycle, then go to CHECK.
- CHECK, length in range [`MIN_LEN`, `MAX_LEN`]:
  - Assert `s_tx_start` with `s_tx_len` = length, then go to WAIT_DONE.
  - Increment the counter of the selected queue.
  - Burst update:
    - High grant while low is available: `burst_cnt` + 1, saturating at `HI_BURST`.
    - High grant with low empty: `burst_cnt` = 0.
    - Low grant: `burst_cnt` = 0.
- CHECK, length out of range:
  - Pulse `s_discard` and return to IDLE.
  - No start, no counter change, no burst change, no gap.
- WAIT_DONE:
  - Remain until `t_tx_done` = 1.
  - On done, go to GAP, or to IDLE if `IFG_CYCLES` = 0.
  - `t_tx_done` outside WAIT_DONE is ignored.
- GAP: a down-counter loads `IFG_CYCLES` − 1; go to IDLE when it reaches 0.
- `s_tx_sel` and `s_tx_len` hold their values from CHECK until the next IDLE selection.
- `avail` changes during POP, CHECK, WAIT_DONE and GAP have no effect.

## Timing
- Arbitration decision in cycle 0 (IDLE), pop in cycle 1, start or discard in cycle 2. Start latency from IDLE with `avail` high is 2 cycles.
- Done in cycle D gives GAP for cycles D+1 to D+`IFG_CYCLES`, IDLE in cycle D+`IFG_CYCLES`+1, and the earliest next pop in D+`IFG_CYCLES`+2.
- After a discard, IDLE is in cycle 3 and the next pop is in cycle 4.
- At most one pop per frame; `s_hi_pop` and `s_lo_pop` are never asserted together.
- Counters wrap from 16'hFFFF to 16'h0000.

## Structure
- Shared package `xmit_pkg`:
  - State enum.
  - Control-word width (24).
  - Length field slice constants (`CTRL_LEN_MSB` = 11, `CTRL_LEN_LSB` = 0).
  - Length width (12).
- Single module; no sub-module is warranted. The gap counter and burst counter are inline.

## Test plan
- Reset, then high FIFO holds one word 24'h040040 with low empty → `s_hi_pop` at cycle 1, `s_tx_start` at cycle 2 with `s_tx_sel` = 1 and `s_tx_len` = 64. After `t_tx_done`, `s_busy` stays high for 12 more cycles; `s_hi_count` = 1.
- Both FIFOs continuously available, `HI_BURST` = 4 → grant order H,H,H,H,L,H,H,H,H,L. After 10 frames, `s_hi_count` = 8 and `s_lo_count` = 2.
- Low only, word 24'h200200 → start with `s_tx_sel` = 0 and `s_tx_len` = 512. A high word arriving during WAIT_DONE is granted next.
- Words with length 12'd0 and then 12'd2000 → two `s_discard` pulses, 3 cycles apart. No `s_tx_start`, counters unchanged, pops still issued.
- `reset_n` low for one cycle during WAIT_DONE → next cycle all outputs are 0 and the state is IDLE. A later `t_tx_done` pulse produces no GAP.
- `IFG_CYCLES` = 0 with back-to-back high frames → the next pop occurs 2 cycles after `t_tx_done`.
